// File: rtl/write_port_arbiter.sv
// write_port_arbiter: round-robin arbiter sharing one FIFO write port
// among NUM_REQ requesters, with bursts of up to MAX_BURST words per grant.
// Optional feature: define WARB_STATS_EN to add per-requester counters
// of acknowledged words (stat_clr / stat_words ports).
module write_port_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                           wclk,
    input  logic                           wrst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   wdata_in,
    input  logic                           wfull,
`ifdef WARB_STATS_EN
    input  logic                           stat_clr,
    output logic [NUM_REQ*16-1:0]          stat_words,
`endif
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           winc,
    output logic [DATA_SIZE-1:0]           wdata,
    output logic                           busy
);

    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic [OW-1:0]       owner;
    logic [OW-1:0]       last_owner;
    logic [OW-1:0]       sel;
    logic [CW-1:0]       cnt;
    logic                last_word;
    logic [DATA_SIZE-1:0] din [NUM_REQ];

    // Unpack the requester data bus into an indexable array
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign din[g] = wdata_in[g*DATA_SIZE +: DATA_SIZE];
    end

    // Round-robin pick: first requester after last_owner (wrapping)
    always_comb begin
        int unsigned idx;
        idx = 0;
        sel = last_owner;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx = (32'(last_owner) + k) % NUM_REQ;
            if (req[OW'(idx)]) begin
                sel = OW'(idx);
            end
        end
    end

    // Write strobe, per-requester ack and data mux for the current owner
    always_comb begin
        winc      = busy & req[owner] & ~wfull & ~wrst;
        ack       = grant & {NUM_REQ{winc}};
        wdata     = busy ? din[owner] : '0;
        last_word = (cnt == CW'(MAX_BURST - 1));
    end

    // Arbiter FSM: pick an owner in IDLE, stream its burst in GRANT
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            cnt        <= '0;
            grant      <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= GRANT;
                        owner      <= sel;
                        last_owner <= sel;
                        cnt        <= '0;
                        grant      <= NUM_REQ'(1) << sel;
                        busy       <= 1'b1;
                    end
                end
                GRANT: begin
                    if ((winc && last_word) || !req[owner]) begin
                        state <= IDLE;
                        cnt   <= '0;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (winc) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        // Saturating count of accepted words; clear beats increment
        always_ff @(posedge wclk) begin
            if (wrst || stat_clr) begin
                stat_q[g] <= '0;
            end else if (ack[g] && (stat_q[g] != 16'hFFFF)) begin
                stat_q[g] <= stat_q[g] + 16'd1;
            end
        end
        assign stat_words[g*16 +: 16] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_write_port_arbiter.sv
// Directed self-checking bench for write_port_arbiter (default parameters).
module tb_write_port_arbiter;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req;
    logic [31:0] wdata_in;
    logic        wfull;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;
`ifdef WARB_STATS_EN
    logic        stat_clr;
    logic [63:0] stat_words;
`endif

    int n_pass  = 0;
    int n_total = 0;

    write_port_arbiter #(.NUM_REQ(4), .DATA_SIZE(8), .MAX_BURST(4)) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .wdata_in (wdata_in),
        .wfull    (wfull),
`ifdef WARB_STATS_EN
        .stat_clr (stat_clr),
        .stat_words(stat_words),
`endif
        .grant    (grant),
        .ack      (ack),
        .winc     (winc),
        .wdata    (wdata),
        .busy     (busy)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        req  = 4'b0000;
        wfull = 1'b0;
        tick();
        tick();
        wrst = 1'b0;
        #1;
    endtask

    initial begin
        int owners [5];
        owners   = '{0, 1, 2, 3, 0};
        wdata_in = 32'h44332211;
        wrst     = 1'b1;
        req      = 4'b0000;
        wfull    = 1'b0;
`ifdef WARB_STATS_EN
        stat_clr = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_winc",  32'(winc),  32'h0);
        check("rst_ack",   32'(ack),   32'h0);
        check("rst_wdata", 32'(wdata), 32'h0);

        // Single requester, full burst of four words then release
        wrst = 1'b0;
        req  = 4'b0001;
        #1;
        check("idle_winc", 32'(winc), 32'h0);
        tick();
        check("b0_grant", 32'(grant), 32'h1);
        check("b0_busy",  32'(busy),  32'h1);
        check("b0_wdata", 32'(wdata), 32'h11);
        for (int w = 0; w < 4; w++) begin
            check("b0_ack", 32'(ack), 32'h1);
            tick();
        end
        check("b0_rel_grant", 32'(grant), 32'h0);
        check("b0_rel_winc",  32'(winc),  32'h0);
        check("b0_rel_wdata", 32'(wdata), 32'h0);
        req = 4'b0000;
        tick();

        // All requesting: rotation 0,1,2,3,0 with one idle gap between grants
        do_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("rr_grant", 32'(grant), 32'(4'b0001 << owners[i]));
            check("rr_wdata", 32'(wdata), 32'((8'h11) * (owners[i] + 1)));
            for (int w = 0; w < 4; w++) begin
                check("rr_ack", 32'(ack), 32'(4'b0001 << owners[i]));
                tick();
            end
            check("rr_gap", 32'(grant), 32'h0);
            tick();
        end
        req = 4'b0000;

        // Owner 2 stalled by wfull for three cycles mid-burst
        do_reset();
        req = 4'b0100;
        tick();
        check("wf_grant", 32'(grant), 32'h4);
        for (int w = 0; w < 2; w++) begin
            check("wf_ack_pre", 32'(ack), 32'h4);
            tick();
        end
        wfull = 1'b1;
        for (int w = 0; w < 3; w++) begin
            #1;
            check("wf_stall_winc",  32'(winc),  32'h0);
            check("wf_stall_ack",   32'(ack),   32'h0);
            check("wf_stall_grant", 32'(grant), 32'h4);
            tick();
        end
        wfull = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            check("wf_ack_post", 32'(ack), 32'h4);
            tick();
        end
        check("wf_rel", 32'(grant), 32'h0);
        req = 4'b0000;
        tick();

        // Owner 1 drops request after two words; requester 3 follows
        do_reset();
        req = 4'b1010;
        tick();
        check("dr_grant1", 32'(grant), 32'h2);
        for (int w = 0; w < 2; w++) begin
            check("dr_ack1", 32'(ack), 32'h2);
            tick();
        end
        req = 4'b1000;
        #1;
        check("dr_nowinc", 32'(winc),  32'h0);
        check("dr_noack3", 32'(ack),   32'h0);
        tick();
        check("dr_release", 32'(grant), 32'h0);
        tick();
        check("dr_grant3", 32'(grant), 32'h8);
        check("dr_ack3",   32'(ack),   32'h8);
        req = 4'b0000;
        tick();

        // Reset mid-burst, then requester 0 wins first
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        tick();
        check("mr_busy", 32'(busy), 32'h1);
        wrst = 1'b1;
        #1;
        check("mr_rst_winc", 32'(winc), 32'h0);
        tick();
        check("mr_grant", 32'(grant), 32'h0);
        check("mr_winc",  32'(winc),  32'h0);
        check("mr_busyq", 32'(busy),  32'h0);
        wrst = 1'b0;
        req  = 4'b1111;
        tick();
        check("mr_first", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();
        tick();

`ifdef WARB_STATS_EN
        // Ten words from requester 3, then clear with a same-cycle ack
        begin
            int acked;
            do_reset();
            acked = 0;
            req = 4'b1000;
            for (int c = 0; c < 40 && acked < 10; c++) begin
                #1;
                if (ack[3]) acked++;
                tick();
            end
            req = 4'b0000;
            check("st_acked", 32'(acked), 32'd10);
            check("st_words", 32'(stat_words[63:48]), 32'd10);
            tick();
            req = 4'b1000;
            for (int c = 0; c < 10 && !ack[3]; c++) begin
                tick();
            end
            check("st_ackseen", 32'(ack[3]), 32'h1);
            stat_clr = 1'b1;
            tick();
            stat_clr = 1'b0;
            req = 4'b0000;
            check("st_clr", 32'(stat_words[63:48]), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
